// File: rtl/local_bus_arbiter.sv
// Round-robin arbiter for the shared local register bus: grants one master at a time
// and sequences SETUP, STROBE, optional read WAIT and a one-cycle ACK back to the winner.
module local_bus_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                     axi_aclk,
    input  logic                     axi_aresetn,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ack,
    output logic [DATA_W-1:0]        req_rdata,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic                     bus_read,
    output logic                     bus_write,
    output logic [DATA_W-1:0]        bus_wdata,
    input  logic [DATA_W-1:0]        bus_rdata,
    output logic                     bus_busy,
    output logic [2:0]               grant_idx
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, ACK} state_t;

    state_t            state;
    logic [2:0]        rr_ptr;
    logic [3:0]        wait_cnt;
    logic              lat_we;

    logic              win_found;
    logic [2:0]        win_idx;
    logic [2:0]        win_next;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // Scan from rr_ptr with wraparound; the first active request wins.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = 3'(idx);
                win_we    = req_we[idx];
                win_addr  = req_addr[idx*ADDR_W +: ADDR_W];
                win_wdata = req_wdata[idx*DATA_W +: DATA_W];
            end
        end
        win_next = 3'((int'(win_idx) + 1) % NREQ);
    end

    // Bus outputs are registered alongside the state they belong to, so the
    // address and data captured at grant are what the bus sees until ACK.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            req_ack   <= '0;
            req_rdata <= '0;
            bus_addr  <= '0;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            bus_wdata <= '0;
            bus_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= SETUP;
                        grant_idx <= win_idx;
                        rr_ptr    <= win_next;
                        lat_we    <= win_we;
                        bus_addr  <= win_addr;
                        bus_wdata <= win_we ? win_wdata : '0;
                        bus_busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    state     <= STROBE;
                    bus_read  <= !lat_we;
                    bus_write <= lat_we;
                end
                STROBE: begin
                    bus_read  <= 1'b0;
                    bus_write <= 1'b0;
                    if (lat_we) begin
                        state     <= ACK;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        req_ack   <= NREQ'(1) << grant_idx;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'(RD_LAT - 1)) begin
                        state     <= ACK;
                        req_rdata <= bus_rdata;
                        req_ack   <= NREQ'(1) << grant_idx;
                        bus_addr  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ACK: begin
                    state    <= IDLE;
                    req_ack  <= '0;
                    bus_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_local_bus_arbiter.sv
// Directed bench for local_bus_arbiter: a 2-requester instance with RD_LAT=3 and a
// 4-requester instance with RD_LAT=1, checked cycle by cycle against hand-derived values.
module tb_local_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [1:0]  v2, we2, ack2;
    logic [31:0] addr2;
    logic [63:0] wd2;
    logic [31:0] rdata2, bwd2, brdata2;
    logic [15:0] baddr2;
    logic        brd2, bwr2, busy2;
    logic [2:0]  gidx2;

    logic [3:0]   v4, we4, ack4;
    logic [63:0]  addr4;
    logic [127:0] wd4;
    logic [31:0]  rdata4, bwd4, brdata4;
    logic [15:0]  baddr4;
    logic         brd4, bwr4, busy4;
    logic [2:0]   gidx4;

    assign brdata2 = (baddr2 == 16'h0020) ? 32'h12345678 : {16'hA5A5, baddr2};
    assign brdata4 = 32'h0;

    local_bus_arbiter #(.NREQ(2), .ADDR_W(16), .DATA_W(32), .RD_LAT(3)) dut2 (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .req_valid(v2), .req_we(we2), .req_addr(addr2), .req_wdata(wd2),
        .req_ack(ack2), .req_rdata(rdata2),
        .bus_addr(baddr2), .bus_read(brd2), .bus_write(bwr2), .bus_wdata(bwd2),
        .bus_rdata(brdata2), .bus_busy(busy2), .grant_idx(gidx2));

    local_bus_arbiter #(.NREQ(4), .ADDR_W(16), .DATA_W(32), .RD_LAT(1)) dut4 (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .req_valid(v4), .req_we(we4), .req_addr(addr4), .req_wdata(wd4),
        .req_ack(ack4), .req_rdata(rdata4),
        .bus_addr(baddr4), .bus_read(brd4), .bus_write(bwr4), .bus_wdata(bwd4),
        .bus_rdata(brdata4), .bus_busy(busy4), .grant_idx(gidx4));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        rst_n = 1'b0;
        v2 = '0; we2 = '0; addr2 = '0; wd2 = '0;
        v4 = '0; we4 = '0; addr4 = '0; wd4 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy2, 0);
        check("rst_ack", ack2, 0);
        check("rst_addr", baddr2, 0);
        check("rst_rdata", rdata2, 0);
        check("rst_gidx", gidx2, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single write, requester 0
        v2 = 2'b01; we2 = 2'b01; addr2[15:0] = 16'h0010; wd2[31:0] = 32'hDEADBEEF;
        @(negedge clk);
        check("wr_c1_write", bwr2, 0);
        check("wr_c1_addr", baddr2, 16'h0010);
        check("wr_c1_busy", busy2, 1);
        @(negedge clk);
        check("wr_c2_write", bwr2, 1);
        check("wr_c2_addr", baddr2, 16'h0010);
        check("wr_c2_wdata", bwd2, 32'hDEADBEEF);
        @(negedge clk);
        check("wr_c3_write", bwr2, 0);
        check("wr_c3_ack", ack2, 2'b01);
        check("wr_c3_addr", baddr2, 0);
        v2 = 2'b00;
        @(negedge clk);
        check("wr_c4_busy", busy2, 0);
        check("wr_c4_ack", ack2, 0);

        // single read, requester 1, RD_LAT=3
        v2 = 2'b10; we2 = 2'b00; addr2[31:16] = 16'h0020;
        @(negedge clk);
        check("rd_c1_read", brd2, 0);
        check("rd_c1_addr", baddr2, 16'h0020);
        check("rd_c1_wdata", bwd2, 0);
        @(negedge clk);
        check("rd_c2_read", brd2, 1);
        check("rd_c2_write", bwr2, 0);
        for (int c = 3; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("rd_c%0d_read", c), brd2, 0);
            check($sformatf("rd_c%0d_addr", c), baddr2, 16'h0020);
            check($sformatf("rd_c%0d_ack", c), ack2, 0);
        end
        @(negedge clk);
        check("rd_c6_ack", ack2, 2'b10);
        check("rd_c6_rdata", rdata2, 32'h12345678);
        check("rd_c6_addr", baddr2, 0);
        check("rd_c6_gidx", gidx2, 1);
        v2 = 2'b00;
        @(negedge clk);

        // both requesters hold valid: grants alternate
        we2 = 2'b11; addr2 = {16'h0200, 16'h0100}; wd2 = {32'h22222222, 32'h11111111};
        v2 = 2'b11;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (ack2 != 2'b00) begin
                check($sformatf("rr_grant%0d", got), ack2, (got % 2 == 0) ? 2'b01 : 2'b10);
                got++;
            end
        end
        v2 = 2'b00;
        check("rr_count", got, 4);
        @(negedge clk);

        // inputs changed after grant must not reach the bus
        v2 = 2'b01; we2 = 2'b01; addr2[15:0] = 16'h0030; wd2[31:0] = 32'h11112222;
        @(negedge clk);
        check("hold_c1_addr", baddr2, 16'h0030);
        addr2[15:0] = 16'hFFFF; wd2[31:0] = 32'h0; we2[0] = 1'b0;
        @(negedge clk);
        check("hold_c2_write", bwr2, 1);
        check("hold_c2_addr", baddr2, 16'h0030);
        check("hold_c2_wdata", bwd2, 32'h11112222);
        @(negedge clk);
        check("hold_c3_ack", ack2, 2'b01);
        v2 = 2'b00;
        @(negedge clk);

        // reset during a read WAIT aborts the transaction
        v2 = 2'b10; we2 = 2'b00; addr2[31:16] = 16'h0020;
        repeat (3) @(negedge clk);
        check("rstw_busy_pre", busy2, 1);
        rst_n = 1'b0;
        #1;
        check("rstw_busy", busy2, 0);
        check("rstw_addr", baddr2, 0);
        check("rstw_read", brd2, 0);
        check("rstw_ack", ack2, 0);
        check("rstw_rdata", rdata2, 0);
        check("rstw_gidx", gidx2, 0);
        v2 = 2'b00;
        @(negedge clk);
        check("rstw_ack_hold", ack2, 0);
        rst_n = 1'b1;
        v2 = 2'b01; we2 = 2'b01; addr2[15:0] = 16'h0004; wd2[31:0] = 32'hCAFE0004;
        @(negedge clk);
        check("post_c1_addr", baddr2, 16'h0004);
        @(negedge clk);
        check("post_c2_write", bwr2, 1);
        check("post_c2_wdata", bwd2, 32'hCAFE0004);
        @(negedge clk);
        check("post_c3_ack", ack2, 2'b01);
        v2 = 2'b00;
        @(negedge clk);

        // NREQ=4: move rr_ptr to 2 by granting requester 1 first
        we4 = 4'b1111; addr4 = {16'h0043, 16'h0042, 16'h0041, 16'h0040};
        v4 = 4'b0010;
        got = 0;
        for (int c = 0; c < 20 && got < 1; c++) begin
            @(negedge clk);
            if (ack4 != 4'b0000) begin
                check("n4_pre_ack", ack4, 4'b0010);
                got++;
            end
        end
        v4 = 4'b0000;
        check("n4_pre_count", got, 1);
        @(negedge clk);
        v4 = 4'b1010;
        got = 0;
        for (int c = 0; c < 30 && got < 2; c++) begin
            @(negedge clk);
            if (ack4 != 4'b0000) begin
                check($sformatf("n4_grant%0d", got), ack4, (got == 0) ? 4'b1000 : 4'b0010);
                if (got == 0) v4 = 4'b0010;
                got++;
            end
        end
        v4 = 4'b0000;
        check("n4_count", got, 2);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
